// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// No logic here: state encoding, widths and the NOP word.
// Imported by if_stage and if_skid_buf.
package if_pkg;

    localparam int XLEN   = 32;
    localparam int JIDX_W = 26;

    localparam logic [XLEN-1:0] NOP = 32'h0000_0000;

    // REQ: fetching at pc; SQUASH: waiting out a stale fetch; HOLD: word parked in skid buffer
    typedef enum logic [1:0] {
        REQ    = 2'd0,
        SQUASH = 2'd1,
        HOLD   = 2'd2
    } if_state_t;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {instr, pc4} park slot for a word that returned while decode was stalled.
// Latency: loaded word visible on the outputs one edge after load.
// Backpressure: none of its own; the fetch FSM stops requesting while the slot is full.
module if_skid_buf
    import if_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            clear,
    input  logic [XLEN-1:0] instr_in,
    input  logic [XLEN-1:0] pc4_in,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc4,
    output logic            valid
);

    // Capture on load, drop on clear; load and clear are never asserted together
    always_ff @(posedge clk) begin
        if (!rst) begin
            instr <= NOP;
            pc4   <= '0;
            valid <= 1'b0;
        end else if (load) begin
            instr <= instr_in;
            pc4   <= pc4_in;
            valid <= 1'b1;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_stage.sv
// MIPS instruction fetch: owns pc, drives req/ack imem port, fills the IF/ID register (IR, nextInst).
// Latency: ack-to-IR is one edge; a zero-wait memory sustains one instruction per cycle.
// Backpressure: stall freezes pc and IF/ID; a word acked under stall parks in a skid buffer (optional IF_SQUASH_CNT_EN adds squash_cnt).
module if_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              PcSrc,
    input  logic [XLEN-1:0]   beqAdr,
    input  logic              jump,
    input  logic [JIDX_W-1:0] jmpAdr,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [XLEN-1:0]   imem_rdata,
    output logic [XLEN-1:0]   IR,
    output logic [XLEN-1:0]   nextInst,
    output logic              if_valid
`ifdef IF_SQUASH_CNT_EN
    ,
    output logic [15:0]       squash_cnt
`endif
);

    if_state_t       state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic [XLEN-1:0] squash_addr, squash_addr_n;
    logic [XLEN-1:0] ir_n, next_inst_n;
    logic            valid_n;

    logic            redir;
    logic [29:0]     target_hi;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] redir_pc;
    logic [1:0]      beq_lsb_unused;

    logic            buf_load, buf_clear, buf_valid;
    logic [XLEN-1:0] buf_instr, buf_pc4;

    // Redirects are only honoured when decode is not stalled; branch beats jump
    assign redir     = (PcSrc | jump) & ~stall;
    assign target_hi = PcSrc ? beqAdr[31:2] : {nextInst[31:28], jmpAdr};
    // pc[1:0] is left untouched by every update, including redirects
    assign redir_pc  = {target_hi, pc[1:0]};
    assign pc_plus4  = pc + 32'd4;
    assign beq_lsb_unused = beqAdr[1:0];

    assign imem_req  = (state != HOLD);
    assign imem_addr = (state == SQUASH) ? squash_addr : pc;

    if_skid_buf u_skid (
        .clk      (clk),
        .rst      (rst),
        .load     (buf_load),
        .clear    (buf_clear),
        .instr_in (imem_rdata),
        .pc4_in   (pc_plus4),
        .instr    (buf_instr),
        .pc4      (buf_pc4),
        .valid    (buf_valid)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= REQ;
        end else begin
            state <= state_n;
        end
    end

    // pc, squash address and IF/ID pipeline register
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc          <= RESET_PC;
            squash_addr <= '0;
            IR          <= NOP;
            nextInst    <= '0;
            if_valid    <= 1'b0;
        end else begin
            pc          <= pc_n;
            squash_addr <= squash_addr_n;
            IR          <= ir_n;
            nextInst    <= next_inst_n;
            if_valid    <= valid_n;
        end
    end

    // Next-state and datapath selection; everything holds unless a branch below says otherwise
    always_comb begin
        state_n       = state;
        pc_n          = pc;
        squash_addr_n = squash_addr;
        ir_n          = IR;
        next_inst_n   = nextInst;
        valid_n       = if_valid;
        buf_load      = 1'b0;
        buf_clear     = 1'b0;

        case (state)
            REQ: begin
                if (redir) begin
                    // Any word arriving now is on the wrong path
                    pc_n    = redir_pc;
                    ir_n    = NOP;
                    valid_n = 1'b0;
                    if (!imem_ack) begin
                        // Keep presenting the old address until memory answers it
                        squash_addr_n = pc;
                        state_n       = SQUASH;
                    end
                end else if (stall) begin
                    if (imem_ack) begin
                        buf_load = 1'b1;
                        pc_n     = pc_plus4;
                        state_n  = HOLD;
                    end
                end else if (imem_ack) begin
                    ir_n        = imem_rdata;
                    next_inst_n = pc_plus4;
                    valid_n     = 1'b1;
                    pc_n        = pc_plus4;
                end else begin
                    ir_n    = NOP;
                    valid_n = 1'b0;
                end
            end
            SQUASH: begin
                if (imem_ack) begin
                    state_n = REQ;
                end
                if (redir) begin
                    pc_n = redir_pc;
                end
                if (!stall) begin
                    ir_n    = NOP;
                    valid_n = 1'b0;
                end
            end
            HOLD: begin
                if (redir) begin
                    buf_clear = 1'b1;
                    ir_n      = NOP;
                    valid_n   = 1'b0;
                    pc_n      = redir_pc;
                    state_n   = REQ;
                end else if (!stall) begin
                    buf_clear   = 1'b1;
                    ir_n        = buf_valid ? buf_instr : NOP;
                    next_inst_n = buf_pc4;
                    valid_n     = buf_valid;
                    state_n     = REQ;
                end
            end
            default: begin
                state_n = REQ;
            end
        endcase
    end

`ifdef IF_SQUASH_CNT_EN
    // Count accepted redirects, wrapping at 16 bits
    always_ff @(posedge clk) begin
        if (!rst) begin
            squash_cnt <= '0;
        end else if (redir) begin
            squash_cnt <= squash_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed steps for the fetch scenarios, then random stall/redirect/ack traffic.
// Expected values come from a program-order stream model: the next delivered word's address.
// Memory returns addr ^ 32'hA5A5_0000 so every word names its own address.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        PcSrc;
    logic [31:0] beqAdr;
    logic        jump;
    logic [25:0] jmpAdr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] IR;
    logic [31:0] nextInst;
    logic        if_valid;
`ifdef IF_SQUASH_CNT_EN
    logic [15:0] squash_cnt;
`endif

    int          checks;
    int          errors;
    logic [31:0] exp_pc;
    logic [15:0] exp_cnt;
    int          delivered;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .PcSrc      (PcSrc),
        .beqAdr     (beqAdr),
        .jump       (jump),
        .jmpAdr     (jmpAdr),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .IR         (IR),
        .nextInst   (nextInst),
        .if_valid   (if_valid)
`ifdef IF_SQUASH_CNT_EN
        ,
        .squash_cnt (squash_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: memory answers the current address, then the stream model judges the edge
    task automatic tick();
        logic        o_rst, o_stall, o_pcsrc, o_jump, o_req, o_ack, o_valid, redir;
        logic [31:0] o_beq, o_ni, o_ir, o_addr, tgt;
        logic [25:0] o_jidx;
        imem_rdata = imem_ack ? word(imem_addr) : $urandom();
        o_rst   = rst;     o_stall = stall;   o_pcsrc = PcSrc;  o_jump = jump;
        o_req   = imem_req; o_ack  = imem_ack; o_valid = if_valid;
        o_beq   = beqAdr;  o_ni    = nextInst; o_ir    = IR;     o_addr = imem_addr;
        o_jidx  = jmpAdr;
        @(posedge clk);
        #1;
        if (!o_rst) begin
            exp_pc  = 32'h0;
            exp_cnt = 16'h0;
            chk("rst_ir", IR, 32'h0);
            chk("rst_next", nextInst, 32'h0);
            chk("rst_valid", {31'b0, if_valid}, 32'h0);
        end else begin
            redir = (o_pcsrc | o_jump) & ~o_stall;
            tgt   = o_pcsrc ? o_beq : {o_ni[31:28], o_jidx, 2'b00};
            if (redir) begin
                exp_pc  = tgt;
                exp_cnt = exp_cnt + 16'd1;
                chk("redir_valid", {31'b0, if_valid}, 32'h0);
                chk("redir_ir", IR, 32'h0);
            end else if (o_stall) begin
                chk("stall_ir", IR, o_ir);
                chk("stall_next", nextInst, o_ni);
                chk("stall_valid", {31'b0, if_valid}, {31'b0, o_valid});
            end else if (if_valid) begin
                chk("stream_ir", IR, word(exp_pc));
                chk("stream_next", nextInst, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end else begin
                chk("bubble_ir", IR, 32'h0);
            end
            if (o_req && !o_ack) begin
                chk("pend_req", {31'b0, imem_req}, 32'h1);
                chk("pend_addr", imem_addr, o_addr);
            end
        end
`ifdef IF_SQUASH_CNT_EN
        chk("squash_cnt", {16'h0, squash_cnt}, {16'h0, exp_cnt});
`endif
    endtask

    initial begin
        checks = 0; errors = 0; exp_pc = 32'h0; exp_cnt = 16'h0; delivered = 0;
        rst = 1'b0; stall = 1'b0; PcSrc = 1'b0; jump = 1'b0;
        beqAdr = 32'h0; jmpAdr = 26'h0; imem_ack = 1'b0; imem_rdata = 32'h0;

        // Reset state
        tick();
        tick();
        chk("rst_req", {31'b0, imem_req}, 32'h1);
        chk("rst_addr", imem_addr, 32'h0);

        // 1: zero-wait memory, one instruction per cycle
        rst = 1'b1; imem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1_ir", IR, word(32'(i * 4)));
            chk("t1_next", nextInst, 32'(i * 4 + 4));
            chk("t1_valid", {31'b0, if_valid}, 32'h1);
        end
        tick();

        // 2: two wait cycles at 0x10
        imem_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("t2_addr", imem_addr, 32'h10);
            tick();
            chk("t2_bub_ir", IR, 32'h0);
            chk("t2_bub_valid", {31'b0, if_valid}, 32'h0);
        end
        chk("t2_addr", imem_addr, 32'h10);
        imem_ack = 1'b1;
        tick();
        chk("t2_ir", IR, word(32'h10));

        // 3: stall coincides with ack of 0x20
        tick(); tick(); tick();
        chk("t3_addr", imem_addr, 32'h20);
        stall = 1'b1;
        tick();
        chk("t3_held_ir", IR, word(32'h1C));
        chk("t3_req_off", {31'b0, imem_req}, 32'h0);
        imem_ack = 1'b0;
        tick();
        stall = 1'b0;
        tick();
        chk("t3_ir", IR, word(32'h20));
        chk("t3_next", nextInst, 32'h24);
        chk("t3_addr2", imem_addr, 32'h24);

        // 4: branch while fetch of 0x30 is pending
        imem_ack = 1'b1;
        tick(); tick(); tick();
        imem_ack = 1'b0; PcSrc = 1'b1; beqAdr = 32'h100;
        tick();
        PcSrc = 1'b0;
        chk("t4_sq_addr", imem_addr, 32'h30);
        tick();
        chk("t4_sq_addr2", imem_addr, 32'h30);
        imem_ack = 1'b1;
        tick();
        chk("t4_discard", IR, 32'h0);
        chk("t4_new_addr", imem_addr, 32'h100);
        tick();
        chk("t4_ir", IR, word(32'h100));

        // 5: jump target formed from nextInst[31:28]; branch wins over jump
        PcSrc = 1'b1; beqAdr = 32'h4000_0004;
        tick();
        PcSrc = 1'b0;
        tick();
        chk("t5_next", nextInst, 32'h4000_0008);
        imem_ack = 1'b0; jump = 1'b1; jmpAdr = 26'h40;
        tick();
        jump = 1'b0;
        imem_ack = 1'b1;
        tick();
        chk("t5_jmp_addr", imem_addr, 32'h4000_0100);
        PcSrc = 1'b1; jump = 1'b1; beqAdr = 32'h200;
        tick();
        PcSrc = 1'b0; jump = 1'b0;
        chk("t5_both_addr", imem_addr, 32'h200);

        // 6: reset in SQUASH with a late ack
        imem_ack = 1'b0; PcSrc = 1'b1; beqAdr = 32'h300;
        tick();
        PcSrc = 1'b0;
        chk("t6_sq_addr", imem_addr, 32'h200);
        rst = 1'b0; imem_ack = 1'b1;
        tick();
        chk("t6_addr", imem_addr, 32'h0);
        chk("t6_ir", IR, 32'h0);
`ifdef IF_SQUASH_CNT_EN
        chk("t6_cnt", {16'h0, squash_cnt}, 32'h0);
`endif
        rst = 1'b1;
        tick();
        chk("t6_first", IR, word(32'h0));

        // Random traffic against the stream model
        delivered = 0;
        for (int i = 0; i < 4000; i++) begin
            rst      = ($urandom_range(0, 299) != 0);
            stall    = ($urandom_range(0, 3) == 0);
            PcSrc    = ($urandom_range(0, 11) == 0);
            jump     = ($urandom_range(0, 11) == 0);
            beqAdr   = $urandom() & 32'hFFFF_FFFC;
            jmpAdr   = 26'($urandom());
            imem_ack = ($urandom_range(0, 1) == 1);
            tick();
        end
        chk("progress", {31'b0, (delivered >= 300)}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the decode stage.
- Owns the PC and drives a req/ack instruction-memory port.
- Registers the fetched word and PC+4 into the IF/ID pipeline register, which feeds decode as IR and nextInst.
- Accepts branch (PcSrc/beqAdr) and jump (jmpAdr) redirects back from decode, and honours hazard-unit stalls.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- stall  in  1  hazard-unit stall; freezes PC and IF/ID.
- PcSrc  in  1  taken branch resolved in decode.
- beqAdr  in  32  branch target from decode.
- jump  in  1  jump decoded in decode.
- jmpAdr  in  26  jump index from decode.
- imem_req  out  1  fetch request, combinational from state.
- imem_addr  out  32  fetch address; stable while imem_req=1 and no ack.
- imem_ack  in  1  data valid this cycle.
- imem_rdata  in  32  instruction word, valid with ack.
- IR  out  32  IF/ID instruction register.
- nextInst  out  32  IF/ID PC+4.
- if_valid  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (rst=0 at an edge):
  - pc←RESET_PC; IR←32'h0 (NOP); nextInst←0; if_valid←0.
  - Skid buffer cleared; state←REQ.
  - Reset overrides every other input, including mid-fetch. Any ack belonging to a pre-reset request is ignored.
- States:
  - REQ: imem_req=1, imem_addr=pc.
  - SQUASH: imem_req=1, imem_addr=stale address held in squash_addr; the returned data will be discarded.
  - HOLD: imem_req=0; one fetched word is parked in the skid buffer.
- Redirect:
  - redir = (PcSrc|jump) & ~stall. PcSrc and jump are ignored while stall=1.
  - Target = beqAdr if PcSrc, else {nextInst[31:28], jmpAdr, 2'b00}. PcSrc wins if both are set.
- REQ:
  - ack & ~stall & ~redir: IR←rdata; nextInst←pc+4; if_valid←1; pc←pc+4. Stay REQ, so a zero-wait memory sustains 1 instruction/cycle.
  - ack & stall: buffer←{rdata, pc+4}; pc←pc+4; IF/ID held; →HOLD.
  - ~ack & ~stall & ~redir: IR←0; if_valid←0 (bubble); stay REQ.
  - ~ack & stall: everything held.
  - redir & ack: data discarded; IR←0; if_valid←0; pc←target; stay REQ.
  - redir & ~ack: squash_addr←pc; pc←target; IR←0; if_valid←0; →SQUASH.
- SQUASH:
  - ack: discard; →REQ.
  - IF/ID takes a bubble when stall=0.
  - A further redir updates pc; squash_addr is unchanged.
- HOLD:
  - ~stall & ~redir: IR/nextInst←buffer; if_valid←1; →REQ.
  - redir: buffer dropped; IR←0; if_valid←0; pc←target; →REQ.
  - stall: held.
- Arithmetic: pc+4 wraps modulo 2^32. Bits [1:0] of pc are never modified by the block.
- IF/ID outputs are registered; the ack-to-IR latency is 1 edge.

Optional Feature:
IF_SQUASH_CNT_EN
- With it: adds output squash_cnt[15:0], reset to 0. It increments by 1 on every edge where redir=1 and rst=1, and wraps at 16'hFFFF→0.
- Without it: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package if_pkg holds:
  - the state enum (REQ, SQUASH, HOLD);
  - the NOP constant 32'h0;
  - the width constants (XLEN=32, JIDX_W=26).
- Sub-module if_skid_buf: 1-entry {instr, pc4} buffer with load/clear/valid; instantiated once.

Test Plan:
1. Reset, RESET_PC=0, memory acks every cycle with rdata=addr^32'hA5A5_0000 → after 3 edges, IR sequence matches addresses 0,4,8 and nextInst=4,8,12; if_valid=1.
2. ack delayed 2 cycles, stall=0 → imem_addr stays 0x10 for 3 cycles; IF/ID shows 2 bubbles (IR=0, if_valid=0), then IR=word@0x10.
3. stall=1 coincides with ack of 0x20 → IR unchanged; imem_req=0 next cycle. stall→0 → IR=word@0x20, nextInst=0x24, imem_addr=0x24.
4. PcSrc=1, beqAdr=0x100 while fetch of 0x30 pending → imem_addr holds 0x30 until ack; that data never reaches IR; next request is 0x100.
5. jump=1, nextInst=0x4000_0008, jmpAdr=26'h40 → next fetch address 0x4000_0100. With PcSrc=1 simultaneously, beqAdr is used.
6. rst=0 during SQUASH → pc=RESET_PC, IR=0, late ack ignored; squash_cnt=0 (IF_SQUASH_CNT_EN).
